// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single framebuffer RAM port between scan-out, two pixel writers and a clear engine
//   clk, rst                  pixel clock, asynchronous active-high reset
//   hc, vc                    VGA beam position counters
//   scan_addr                 scan-out read address, owns the port outside granted write slots
//   wr_req, wr_ack            per-writer request (held until ack) and one-cycle commit pulse
//   wr_addr0/1, wr_data0/1    writer target address and pixel
//   clear_req, clear_color    clear start pulse and fill colour (latched on accept)
//   clear_busy, clear_done    clear running flag and one-cycle completion pulse
//   ram_addr, ram_wdata, ram_we  registered RAM port
module vga_fb_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int H_ACTIVE   = 640,
   parameter int H_TOTAL    = 800,
   parameter int V_ACTIVE   = 480,
   parameter int CLEAR_LAST = 19199
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        hc,
   input  logic [9:0]        vc,
   input  logic [ADDR_W-1:0] scan_addr,
   input  logic [1:0]        wr_req,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        wr_ack,
   input  logic              clear_req,
   input  logic [DATA_W-1:0] clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we
);
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] CLEAR = 1'b1;
   logic [0:0]        state;
   logic              rr_ptr;
   logic [ADDR_W-1:0] clr_addr;
   logic [DATA_W-1:0] color;
   logic              win;
   logic              gnt;
   // the last blank clock is excluded because the registered write would land on the first visible pixel
   assign win = (vc >= 10'(V_ACTIVE)) | (hc >= 10'(H_ACTIVE) && hc < 10'(H_TOTAL - 1));
   assign gnt = (&wr_req) ? rr_ptr : wr_req[1];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= 1'b0;
         clr_addr   <= '0;
         color      <= '0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_we     <= 1'b0;
         wr_ack     <= 2'b00;
         clear_busy <= 1'b0;
         clear_done <= 1'b0;
      end else begin
         ram_addr   <= scan_addr;
         ram_we     <= 1'b0;
         wr_ack     <= 2'b00;
         clear_done <= 1'b0;
         if (state == IDLE) begin
            if (clear_req) begin
               state      <= CLEAR;
               clr_addr   <= '0;
               color      <= clear_color;
               clear_busy <= 1'b1;
            end else if (win && |wr_req) begin
               ram_addr  <= gnt ? wr_addr1 : wr_addr0;
               ram_wdata <= gnt ? wr_data1 : wr_data0;
               ram_we    <= 1'b1;
               wr_ack    <= gnt ? 2'b10 : 2'b01;
               if (&wr_req) rr_ptr <= ~gnt;
            end
         end else if (win) begin
            ram_addr  <= clr_addr;
            ram_wdata <= color;
            ram_we    <= 1'b1;
            clr_addr  <= clr_addr + 1'b1;
            if (clr_addr == ADDR_W'(CLEAR_LAST)) begin
               state      <= IDLE;
               clear_busy <= 1'b0;
               clear_done <= 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed checks of windowing, round-robin, clear and reset behaviour
module tb_vga_fb_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hc, vc;
   logic [15:0] scan_addr, wr_addr0, wr_addr1, ram_addr;
   logic [1:0]  wr_req, wr_ack;
   logic [7:0]  wr_data0, wr_data1, clear_color, ram_wdata;
   logic        clear_req, clear_busy, clear_done, ram_we;
   int          n_cmp = 0;
   int          n_bad = 0;

   vga_fb_arbiter dut (
      .clk(clk), .rst(rst), .hc(hc), .vc(vc), .scan_addr(scan_addr),
      .wr_req(wr_req), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
      .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_ack(wr_ack),
      .clear_req(clear_req), .clear_color(clear_color),
      .clear_busy(clear_busy), .clear_done(clear_done),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we)
   );

   always #5 clk = ~clk;

   // one clock: outputs are sampled 1 time unit after the edge, then the beam advances
   task automatic step();
      @(posedge clk);
      #1;
      if (hc == 10'd799) begin
         hc = 10'd0;
         vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
      end else hc = hc + 10'd1;
   endtask

   function automatic bit win_f(input logic [9:0] h, input logic [9:0] v);
      return (v >= 10'd480) || (h >= 10'd640 && h < 10'd799);
   endfunction

   task automatic test_reset();
      rst = 1'b1; hc = 10'd0; vc = 10'd0; scan_addr = 16'hBEEF;
      wr_req = 2'b00; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
      clear_req = 1'b0; clear_color = '0;
      step(); step();
      n_cmp++;
      if ({ram_addr, ram_wdata, ram_we, wr_ack, clear_busy, clear_done} !== 30'd0) begin
         n_bad++; $display("FAIL reset_init: got addr=%h wdata=%h we=%b ack=%b busy=%b done=%b want all 0",
                           ram_addr, ram_wdata, ram_we, wr_ack, clear_busy, clear_done);
      end
      rst = 1'b0; hc = 10'd100; vc = 10'd490;
      wr_req = 2'b01; wr_addr0 = 16'h4321; wr_data0 = 8'h77;
      step();
      n_cmp++;
      if ({ram_we, wr_ack, ram_addr, ram_wdata} !== {1'b1, 2'b01, 16'h4321, 8'h77}) begin
         n_bad++; $display("FAIL reset_prewrite: got we=%b ack=%b addr=%h wdata=%h want 1 01 4321 77",
                           ram_we, wr_ack, ram_addr, ram_wdata);
      end
      wr_req = 2'b00;
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({ram_addr, ram_wdata, ram_we, wr_ack, clear_busy, clear_done} !== 30'd0) begin
         n_bad++; $display("FAIL reset_async: got addr=%h wdata=%h we=%b ack=%b busy=%b done=%b want all 0",
                           ram_addr, ram_wdata, ram_we, wr_ack, clear_busy, clear_done);
      end
      step(); step();
      rst = 1'b0;
   endtask

   task automatic test_active_block();
      logic [9:0] ph;
      hc = 10'd100; vc = 10'd50; scan_addr = 16'hABCD;
      wr_req = 2'b01; wr_addr0 = 16'h1234; wr_data0 = 8'h5A;
      for (int i = 0; i < 540; i++) begin
         ph = hc;
         step();
         n_cmp++;
         if ({ram_we, wr_ack, ram_addr} !== {1'b0, 2'b00, 16'hABCD}) begin
            n_bad++; $display("FAIL active_block hc=%0d: got we=%b ack=%b addr=%h want 0 00 abcd",
                              ph, ram_we, wr_ack, ram_addr);
         end
      end
      step();
      n_cmp++;
      if ({ram_we, wr_ack, ram_addr, ram_wdata} !== {1'b1, 2'b01, 16'h1234, 8'h5A}) begin
         n_bad++; $display("FAIL active_first_write: got we=%b ack=%b addr=%h wdata=%h want 1 01 1234 5a",
                           ram_we, wr_ack, ram_addr, ram_wdata);
      end
      wr_req = 2'b00;
      step();
      n_cmp++;
      if ({ram_we, wr_ack} !== 3'b000) begin
         n_bad++; $display("FAIL active_after_ack: got we=%b ack=%b want 0 00", ram_we, wr_ack);
      end
   endtask

   task automatic test_guard_clock();
      int first_h = -1;
      int first_v = -1;
      logic [9:0] ph, pv;
      hc = 10'd799; vc = 10'd10;
      wr_req = 2'b01; wr_addr0 = 16'h0F0F; wr_data0 = 8'hC3;
      for (int i = 0; i < 1700; i++) begin
         ph = hc; pv = vc;
         step();
         if (ram_we || wr_ack != 2'b00) begin
            first_h = int'(ph); first_v = int'(pv);
            break;
         end
      end
      n_cmp++;
      if (first_h != 640 || first_v != 11 || wr_ack !== 2'b01 || ram_addr !== 16'h0F0F || ram_wdata !== 8'hC3) begin
         n_bad++; $display("FAIL guard_clock: got first write at hc=%0d vc=%0d ack=%b addr=%h wdata=%h want hc=640 vc=11 01 0f0f c3",
                           first_h, first_v, wr_ack, ram_addr, ram_wdata);
      end
      wr_req = 2'b00;
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_ack;
      logic [15:0] exp_addr;
      logic [7:0]  exp_data;
      hc = 10'd0; vc = 10'd490;
      wr_req = 2'b11;
      wr_addr0 = 16'd100; wr_data0 = 8'h10;
      wr_addr1 = 16'd200; wr_data1 = 8'h20;
      for (int i = 0; i < 4; i++) begin
         step();
         exp_ack  = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (i % 2 == 0) ? 16'(100 + i / 2) : 16'(200 + i / 2);
         exp_data = (i % 2 == 0) ? 8'(16 + i / 2) : 8'(32 + i / 2);
         n_cmp++;
         if ({ram_we, wr_ack, ram_addr, ram_wdata} !== {1'b1, exp_ack, exp_addr, exp_data}) begin
            n_bad++; $display("FAIL round_robin[%0d]: got we=%b ack=%b addr=%0d wdata=%h want 1 %b %0d %h",
                              i, ram_we, wr_ack, ram_addr, ram_wdata, exp_ack, exp_addr, exp_data);
         end
         if (wr_ack[0]) begin wr_addr0 = wr_addr0 + 16'd1; wr_data0 = wr_data0 + 8'd1; end
         if (wr_ack[1]) begin wr_addr1 = wr_addr1 + 16'd1; wr_data1 = wr_data1 + 8'd1; end
      end
      wr_req = 2'b00;
      step();
   endtask

   task automatic test_clear();
      int nw = 0;
      int errs = 0;
      bit done = 0;
      bit ok;
      bit got;
      logic [9:0] ph, pv;
      hc = 10'd0; vc = 10'd505;
      clear_color = 8'hE0; clear_req = 1'b1;
      wr_req = 2'b01; wr_addr0 = 16'h7777; wr_data0 = 8'h11;
      step();
      clear_req = 1'b0; clear_color = 8'h00;
      n_cmp++;
      if ({clear_busy, ram_we, wr_ack} !== 4'b1000) begin
         n_bad++; $display("FAIL clear_accept: got busy=%b we=%b ack=%b want 1 0 00", clear_busy, ram_we, wr_ack);
      end
      for (int i = 0; i < 40000; i++) begin
         ph = hc; pv = vc;
         step();
         ok = (wr_ack === 2'b00);
         if (ram_we) begin
            ok = ok && win_f(ph, pv) && ram_addr === 16'(nw) && ram_wdata === 8'hE0;
            nw++;
         end
         if (clear_done) done = 1;
         else ok = ok && (clear_busy === 1'b1);
         n_cmp++;
         if (!ok) begin
            n_bad++;
            if (errs++ < 8) $display("FAIL clear_write hc=%0d vc=%0d: got we=%b addr=%0d wdata=%h ack=%b busy=%b want addr=%0d wdata=e0 ack=00 busy=1 in win",
                                     ph, pv, ram_we, ram_addr, ram_wdata, wr_ack, clear_busy, nw - 1);
         end
         if (done) break;
      end
      n_cmp++;
      if (!done || nw != 19200 || clear_busy !== 1'b0 || ram_we !== 1'b1) begin
         n_bad++; $display("FAIL clear_done: got done=%b writes=%0d busy=%b we=%b want 1 19200 0 1",
                           done, nw, clear_busy, ram_we);
      end
      step();
      n_cmp++;
      if (clear_done !== 1'b0) begin
         n_bad++; $display("FAIL clear_done_pulse: got done=%b want 0", clear_done);
      end
      got = 0;
      for (int i = 0; i < 1700; i++) begin
         if (wr_ack !== 2'b00) begin got = 1; break; end
         step();
      end
      n_cmp++;
      if (!got || {wr_ack, ram_addr, ram_wdata, ram_we} !== {2'b01, 16'h7777, 8'h11, 1'b1}) begin
         n_bad++; $display("FAIL clear_pending_write: got seen=%b ack=%b addr=%h wdata=%h we=%b want 1 01 7777 11 1",
                           got, wr_ack, ram_addr, ram_wdata, ram_we);
      end
      wr_req = 2'b00;
      step();
   endtask

   task automatic test_clear_abort();
      bit found = 0;
      int errs = 0;
      hc = 10'd0; vc = 10'd480;
      clear_color = 8'h1C; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         step();
         if (ram_we && ram_addr == 16'd5000) begin found = 1; break; end
      end
      n_cmp++;
      if (!found || ram_wdata !== 8'h1C || clear_busy !== 1'b1) begin
         n_bad++; $display("FAIL abort_reach_5000: got seen=%b wdata=%h busy=%b want 1 1c 1", found, ram_wdata, clear_busy);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({clear_busy, clear_done, ram_we, ram_addr} !== 19'd0) begin
         n_bad++; $display("FAIL abort_reset: got busy=%b done=%b we=%b addr=%h want 0 0 0 0000",
                           clear_busy, clear_done, ram_we, ram_addr);
      end
      step(); step();
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         n_cmp++;
         if ({clear_busy, clear_done, ram_we} !== 3'b000) begin
            n_bad++;
            if (errs++ < 4) $display("FAIL abort_idle[%0d]: got busy=%b done=%b we=%b want 0 0 0",
                                     i, clear_busy, clear_done, ram_we);
         end
      end
      clear_color = 8'h03; clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      n_cmp++;
      if (clear_busy !== 1'b1) begin
         n_bad++; $display("FAIL abort_restart_busy: got busy=%b want 1", clear_busy);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'(i), 8'h03}) begin
            n_bad++; $display("FAIL abort_restart[%0d]: got we=%b addr=%0d wdata=%h want 1 %0d 03",
                              i, ram_we, ram_addr, ram_wdata, i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_active_block();
      test_guard_clock();
      test_round_robin();
      test_clear();
      test_clear_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
